// File: rtl/maxpool_pkg.sv
// Shared constants for the 3x3 max-pool window generator and the downstream max-find stage.
package maxpool_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam int STRIDE_1 = 1;
  localparam int STRIDE_2 = 2;

  // Window element indices, row-major, 0 = oldest row / oldest column.
  localparam int WIN_00 = 0;
  localparam int WIN_01 = 1;
  localparam int WIN_02 = 2;
  localparam int WIN_10 = 3;
  localparam int WIN_11 = 4;
  localparam int WIN_12 = 5;
  localparam int WIN_20 = 6;
  localparam int WIN_21 = 7;
  localparam int WIN_22 = 8;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_window_3x3_if.sv
// Pixel stream in / 3x3 window out bundle; MAXPOOL_SOF_SYNC_EN adds Sof_In.
interface maxpool_window_3x3_if #(
  parameter int DATA_WIDTH = maxpool_pkg::DATA_WIDTH_DEF
);
  logic [DATA_WIDTH-1:0] Data_In;
  logic                  Valid_In;
`ifdef MAXPOOL_SOF_SYNC_EN
  logic                  Sof_In;
`endif
  logic [DATA_WIDTH-1:0] Data_Out0, Data_Out1, Data_Out2;
  logic [DATA_WIDTH-1:0] Data_Out3, Data_Out4, Data_Out5;
  logic [DATA_WIDTH-1:0] Data_Out6, Data_Out7, Data_Out8;
  logic                  Valid_Out;
  logic                  Frame_Done;

`ifdef MAXPOOL_SOF_SYNC_EN
  modport master (
    output Data_In, Valid_In, Sof_In,
    input  Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
           Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
  );
  modport slave (
    input  Data_In, Valid_In, Sof_In,
    output Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
           Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
  );
`else
  modport master (
    output Data_In, Valid_In,
    input  Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
           Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
  );
  modport slave (
    input  Data_In, Valid_In,
    output Data_Out0, Data_Out1, Data_Out2, Data_Out3, Data_Out4,
           Data_Out5, Data_Out6, Data_Out7, Data_Out8, Valid_Out, Frame_Done
  );
`endif

endinterface

// File: rtl/maxpool_line_buffer.sv
// Enable-gated delay of DEPTH accepted words: circular RAM, one wrapping pointer.
// rd_dat is the word written DEPTH enables ago; read and write share the pointer.
module maxpool_line_buffer
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  localparam int PW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         ptr_q, ptr_d;

  assign rd_dat = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= wr_dat;
    end
  end

endmodule

// File: rtl/maxpool_window_3x3.sv
// Raster pixel stream -> strided 3x3 windows, one-cycle registered latency, no backpressure.
// Optional MAXPOOL_SOF_SYNC_EN: Sof_In with Valid_In forces the pixel to (0,0).
module maxpool_window_3x3
  import maxpool_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int STRIDE     = STRIDE_2
) (
  input  logic                 clk,
  input  logic                 rst,
  maxpool_window_3x3_if.slave  bus
);

  localparam int  CW  = cnt_width(IMG_W);
  localparam int  RW  = cnt_width(IMG_H);
  localparam bit  ST2 = (STRIDE == STRIDE_2);

  logic [DATA_WIDTH-1:0] win_q  [9];
  logic [DATA_WIDTH-1:0] win_d  [9];
  logic [DATA_WIDTH-1:0] dout_q [9];
  logic [DATA_WIDTH-1:0] dout_d [9];
  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  logic          col_ph_q, col_ph_d, col_ph_c;
  logic          row_ph_q, row_ph_d, row_ph_c;
  logic          vout_q, vout_d, fd_q, fd_d;
  logic          acc, sof_start, col_last, row_last, emit;
  logic [DATA_WIDTH-1:0] lb0_out, lb1_out;

  assign acc = bus.Valid_In;
`ifdef MAXPOOL_SOF_SYNC_EN
  assign sof_start = bus.Valid_In & bus.Sof_In;
`else
  assign sof_start = 1'b0;
`endif

  // Position of the pixel being accepted; a start-of-frame overrides the counters.
  assign col_c    = sof_start ? '0   : col_q;
  assign row_c    = sof_start ? '0   : row_q;
  assign col_ph_c = sof_start ? 1'b0 : col_ph_q;
  assign row_ph_c = sof_start ? 1'b0 : row_ph_q;
  assign col_last = (col_c == CW'(IMG_W - 1));
  assign row_last = (row_c == RW'(IMG_H - 1));
  assign emit     = acc && (row_c >= RW'(2)) && (col_c >= CW'(2)) && !col_ph_c && !row_ph_c;

  maxpool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst(rst), .en(acc), .wr_dat(bus.Data_In), .rd_dat(lb0_out)
  );

  maxpool_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst(rst), .en(acc), .wr_dat(lb0_out), .rd_dat(lb1_out)
  );

  always_comb begin
    win_d    = win_q;
    dout_d   = dout_q;
    col_d    = col_q;
    row_d    = row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    vout_d   = 1'b0;
    fd_d     = 1'b0;
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r*3+0] = win_q[r*3+1];
        win_d[r*3+1] = win_q[r*3+2];
      end
      win_d[WIN_02] = lb1_out;
      win_d[WIN_12] = lb0_out;
      win_d[WIN_22] = bus.Data_In;

      row_d    = row_c;
      row_ph_d = row_ph_c;
      if (col_last) begin
        col_d    = '0;
        col_ph_d = 1'b0;
        if (row_last) begin
          row_d    = '0;
          row_ph_d = 1'b0;
        end else begin
          row_d    = row_c + 1'b1;
          row_ph_d = (ST2 && row_c >= RW'(2)) ? ~row_ph_c : row_ph_c;
        end
      end else begin
        col_d    = col_c + 1'b1;
        col_ph_d = (ST2 && col_c >= CW'(2)) ? ~col_ph_c : col_ph_c;
      end

      if (emit) begin
        dout_d = win_d;
      end
      vout_d = emit;
      fd_d   = col_last && row_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '{default: '0};
      dout_q   <= '{default: '0};
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= 1'b0;
      row_ph_q <= 1'b0;
      vout_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      win_q    <= win_d;
      dout_q   <= dout_d;
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      vout_q   <= vout_d;
      fd_q     <= fd_d;
    end
  end

  assign bus.Data_Out0  = dout_q[WIN_00];
  assign bus.Data_Out1  = dout_q[WIN_01];
  assign bus.Data_Out2  = dout_q[WIN_02];
  assign bus.Data_Out3  = dout_q[WIN_10];
  assign bus.Data_Out4  = dout_q[WIN_11];
  assign bus.Data_Out5  = dout_q[WIN_12];
  assign bus.Data_Out6  = dout_q[WIN_20];
  assign bus.Data_Out7  = dout_q[WIN_21];
  assign bus.Data_Out8  = dout_q[WIN_22];
  assign bus.Valid_Out  = vout_q;
  assign bus.Frame_Done = fd_q;

endmodule

// File: tb/tb_maxpool_window_3x3.sv
// Directed bench: two 5x5 instances (stride 2 and stride 1) share one pixel stream.
module tb_maxpool_window_3x3;

  typedef logic [287:0] wv_t;

  localparam wv_t W_T1_FIRST = {32'd0, 32'd1, 32'd2, 32'd5, 32'd6, 32'd7, 32'd10, 32'd11, 32'd12};
  localparam wv_t W_T1_LAST  = {32'd12, 32'd13, 32'd14, 32'd17, 32'd18, 32'd19, 32'd22, 32'd23, 32'd24};
  localparam wv_t W_T2_18    = {32'd6, 32'd7, 32'd8, 32'd11, 32'd12, 32'd13, 32'd16, 32'd17, 32'd18};
  localparam wv_t W_T4_FIRST = {32'd100, 32'd101, 32'd102, 32'd105, 32'd106, 32'd107, 32'd110, 32'd111, 32'd112};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        vin;
`ifdef MAXPOOL_SOF_SYNC_EN
  logic        sof;
`endif

  always #5 clk = ~clk;

  maxpool_window_3x3_if #(.DATA_WIDTH(32)) if_a ();
  maxpool_window_3x3_if #(.DATA_WIDTH(32)) if_b ();

  assign if_a.Data_In  = din;
  assign if_a.Valid_In = vin;
  assign if_b.Data_In  = din;
  assign if_b.Valid_In = vin;
`ifdef MAXPOOL_SOF_SYNC_EN
  assign if_a.Sof_In = sof;
  assign if_b.Sof_In = sof;
`endif

  maxpool_window_3x3 #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_dut_a (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  maxpool_window_3x3 #(.DATA_WIDTH(32), .IMG_W(5), .IMG_H(5), .STRIDE(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  int  checks = 0;
  int  errors = 0;
  wv_t last_a, last_b, cap_a_first, cap_a_last, cap_b_18;
  int  nwin_a, nwin_b;
  // Completing-pixel positions, hand-derived for a 5x5 frame.
  logic [24:0] mask_a = 25'b1_0100_0000_0101_0000_0000_0000;
  logic [24:0] mask_b = 25'b1_1100_1110_0111_0000_0000_0000;

  task automatic chk(input string tag, input wv_t got, input wv_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic wv_t win_a();
    return {if_a.Data_Out0, if_a.Data_Out1, if_a.Data_Out2, if_a.Data_Out3, if_a.Data_Out4,
            if_a.Data_Out5, if_a.Data_Out6, if_a.Data_Out7, if_a.Data_Out8};
  endfunction

  function automatic wv_t win_b();
    return {if_b.Data_Out0, if_b.Data_Out1, if_b.Data_Out2, if_b.Data_Out3, if_b.Data_Out4,
            if_b.Data_Out5, if_b.Data_Out6, if_b.Data_Out7, if_b.Data_Out8};
  endfunction

  // Window whose bottom-right pixel is raster index k of a 5-wide frame of values base+idx.
  function automatic wv_t exp_win(input int base, input int k);
    wv_t res;
    int  r, c;
    res = '0;
    r   = k / 5;
    c   = k % 5;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[(8 - (i*3 + j))*32 +: 32] = 32'(base + (r - 2 + i)*5 + (c - 2 + j));
    return res;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_vld_a"}, wv_t'(if_a.Valid_Out), '0);
    chk({tag, "_vld_b"}, wv_t'(if_b.Valid_Out), '0);
    chk({tag, "_fd_a"}, wv_t'(if_a.Frame_Done), '0);
    chk({tag, "_fd_b"}, wv_t'(if_b.Frame_Done), '0);
    chk({tag, "_win_a"}, win_a(), last_a);
    chk({tag, "_win_b"}, win_b(), last_b);
  endtask

  task automatic stall_cycle();
    vin = 1'b0;
    @(posedge clk);
    #1;
    check_idle("stall");
  endtask

  task automatic run_frame(input int base, input int n, input bit stalls, input bit sof_first);
    bit ea, eb;
    nwin_a = 0;
    nwin_b = 0;
    for (int k = 0; k < n; k++) begin
      if (stalls) begin
        for (int s = 0; s < 3 && $urandom_range(1, 0) == 0; s++) stall_cycle();
      end
      din = 32'(base + k);
      vin = 1'b1;
`ifdef MAXPOOL_SOF_SYNC_EN
      sof = sof_first && (k == 0);
`else
      if (sof_first) $display("note: start-of-frame marker not built in");
`endif
      @(posedge clk);
      #1;
      ea = mask_a[k];
      eb = mask_b[k];
      chk("vld_a", wv_t'(if_a.Valid_Out), wv_t'(ea));
      chk("vld_b", wv_t'(if_b.Valid_Out), wv_t'(eb));
      chk("fd_a", wv_t'(if_a.Frame_Done), wv_t'(k == 24));
      chk("fd_b", wv_t'(if_b.Frame_Done), wv_t'(k == 24));
      if (ea) begin
        last_a = exp_win(base, k);
        nwin_a++;
        if (k == 12) cap_a_first = win_a();
        if (k == 24) cap_a_last  = win_a();
      end
      if (eb) begin
        last_b = exp_win(base, k);
        nwin_b++;
        if (k == 18) cap_b_18 = win_b();
      end
      chk("win_a", win_a(), last_a);
      chk("win_b", win_b(), last_b);
    end
    vin = 1'b0;
`ifdef MAXPOOL_SOF_SYNC_EN
    sof = 1'b0;
`endif
  endtask

  task automatic check_full_frame(input string tag);
    chk({tag, "_nwin_a"}, wv_t'(nwin_a), wv_t'(4));
    chk({tag, "_nwin_b"}, wv_t'(nwin_b), wv_t'(9));
    chk({tag, "_first_a"}, cap_a_first, W_T1_FIRST);
    chk({tag, "_last_a"}, cap_a_last, W_T1_LAST);
    chk({tag, "_b_px18"}, cap_b_18, W_T2_18);
  endtask

  task automatic reset_cycle(input string tag);
    rst = 1'b1;
    vin = 1'b0;
    @(posedge clk);
    #1;
    last_a = '0;
    last_b = '0;
    check_idle(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din = '0;
    vin = 1'b0;
`ifdef MAXPOOL_SOF_SYNC_EN
    sof = 1'b0;
`endif
    last_a = '0; last_b = '0;
    cap_a_first = '0; cap_a_last = '0; cap_b_18 = '0;
    @(posedge clk);
    reset_cycle("reset");

    // Tests 1 and 2: full-rate frame, stride 2 and stride 1 in parallel.
    run_frame(0, 25, 1'b0, 1'b0);
    check_full_frame("t1");

    // Test 3: same frame with random stalls.
    cap_a_first = '0; cap_a_last = '0; cap_b_18 = '0;
    run_frame(0, 25, 1'b1, 1'b0);
    check_full_frame("t3");

    // Test 4: two frames back to back, no bubble.
    run_frame(0, 25, 1'b0, 1'b0);
    check_full_frame("t4a");
    run_frame(100, 25, 1'b0, 1'b0);
    chk("t4b_nwin_a", wv_t'(nwin_a), wv_t'(4));
    chk("t4b_first_a", cap_a_first, W_T4_FIRST);

    // Test 5: reset after ten pixels, then a clean frame.
    run_frame(0, 10, 1'b0, 1'b0);
    reset_cycle("t5_rst");
    cap_a_first = '0; cap_a_last = '0; cap_b_18 = '0;
    run_frame(0, 25, 1'b0, 1'b0);
    check_full_frame("t5");

`ifdef MAXPOOL_SOF_SYNC_EN
    // Test 6: stray pixels, then a frame marked with start-of-frame.
    run_frame(200, 7, 1'b0, 1'b0);
    cap_a_first = '0; cap_a_last = '0; cap_b_18 = '0;
    run_frame(0, 25, 1'b0, 1'b1);
    check_full_frame("t6");
`endif

    repeat (2) stall_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
